// File: rtl/arrow_ps2_pkg.sv
// Shared constants, FSM encoding and key helpers for the arrow-key PS/2 transmitter.
package arrow_ps2_pkg;

  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BREAK = 8'hF0;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_RIGHT = 2;
  localparam int KEY_UP    = 3;
  localparam int NUM_KEYS  = 4;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} tx_state_t;

  // Lowest set index wins, which gives left > down > right > up.
  function automatic logic [1:0] first_key(input logic [3:0] flags);
    logic [1:0] sel;
    sel = 2'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (flags[i]) sel = 2'(i);
    end
    return sel;
  endfunction

  function automatic logic [7:0] key_code(input logic [1:0] key);
    logic [7:0] code;
    case (key)
      2'(KEY_LEFT):  code = CODE_LEFT;
      2'(KEY_DOWN):  code = CODE_DOWN;
      2'(KEY_RIGHT): code = CODE_RIGHT;
      default:       code = CODE_UP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ps2_byte_tx.sv
// Serializes one byte as an 11-bit PS/2 frame (start, data LSB first, odd parity, stop),
// generating the PS/2 clock: high for the first half of each bit period, low for the second.
module ps2_byte_tx
  import arrow_ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       done
);

  localparam int PERIOD = 2 * HALF_PERIOD;
  localparam int PW = $clog2(PERIOD);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0] PHASE_HALF = PW'(HALF_PERIOD);
  localparam logic [3:0]    BIT_LAST   = 4'd10;

  logic          active;
  logic [PW-1:0] phase;
  logic [3:0]    bit_idx;
  logic [10:0]   frame;

  // frame[0] is always the bit on the wire; it shifts only at bit-period boundaries.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      active  <= 1'b0;
      phase   <= '0;
      bit_idx <= '0;
      frame   <= '1;
    end else if (start) begin
      active  <= 1'b1;
      phase   <= '0;
      bit_idx <= '0;
      frame   <= {1'b1, ~^data, data, 1'b0};
    end else if (active) begin
      if (phase == PHASE_LAST) begin
        phase <= '0;
        if (bit_idx == BIT_LAST) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          frame   <= {1'b1, frame[10:1]};
        end
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  assign done     = active && (bit_idx == BIT_LAST) && (phase == PHASE_LAST);
  assign ps2_clk  = !active || (phase < PHASE_HALF);
  assign ps2_data = !active || frame[0];

endmodule

// File: rtl/arrow_scancode_tx.sv
// Device-side PS/2 transmitter sending E0-prefixed make codes for arrow-key presses.
// Define ARROW_TX_BREAK_EN to also send E0 F0 <code> break sequences on release.
module arrow_scancode_tx
  import arrow_ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_BITS    = 2
) (
  input  logic clk,
  input  logic areset_n,
  input  logic left,
  input  logic down,
  input  logic right,
  input  logic up,
  output logic ps2_clk,
  output logic ps2_data,
  output logic busy,
  output logic tx_done
);

  localparam int GAP_CYCLES = GAP_BITS * 2 * HALF_PERIOD;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  tx_state_t state, next_state;

  logic [3:0]    keys, key_sync, key_hist, press, pending, clr_make;
  logic [1:0]    make_sel, load_sel, byte_idx, next_idx, last_idx;
  logic [7:0]    code, tx_byte;
  logic [GW-1:0] gap_cnt;
  logic          gap_last, last_byte, start, byte_done, any_pending;

  assign keys      = {up, right, down, left};
  assign press     = key_sync & ~key_hist;
  assign make_sel  = first_key(pending);
  assign clr_make  = (state == LOAD && |pending) ? (4'b0001 << make_sel) : 4'b0000;
  assign gap_last  = (gap_cnt == GAP_LAST);
  assign last_byte = (byte_idx == last_idx);

`ifdef ARROW_TX_BREAK_EN
  logic [3:0] release_det, rel_pending, clr_break;
  logic [1:0] break_sel;
  logic       is_break;

  assign release_det = ~key_sync & key_hist;
  assign break_sel   = first_key(rel_pending);
  assign clr_break   = (state == LOAD && !(|pending)) ? (4'b0001 << break_sel) : 4'b0000;
  assign load_sel    = (|pending) ? make_sel : break_sel;
  assign any_pending = (|pending) || (|rel_pending);
  assign last_idx    = is_break ? 2'd2 : 2'd1;

  // Breaks are only chosen once every make has drained.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rel_pending <= '0;
      is_break    <= 1'b0;
    end else begin
      rel_pending <= (rel_pending & ~clr_break) | release_det;
      if (state == LOAD) is_break <= !(|pending);
    end
  end
`else
  assign load_sel    = make_sel;
  assign any_pending = |pending;
  assign last_idx    = 2'd1;
`endif

  // Key sync stage plus history; a new press survives a same-cycle clear of its flag.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      key_sync <= '0;
      key_hist <= '0;
      pending  <= '0;
      code     <= '0;
      byte_idx <= '0;
      gap_cnt  <= '0;
    end else begin
      key_sync <= keys;
      key_hist <= key_sync;
      pending  <= (pending & ~clr_make) | press;
      if (state == LOAD) begin
        code     <= key_code(load_sel);
        byte_idx <= '0;
      end else if (start) begin
        byte_idx <= next_idx;
      end
      gap_cnt <= (state == GAP && !gap_last) ? gap_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (any_pending) next_state = LOAD;
      LOAD:  next_state = SHIFT;
      SHIFT: if (byte_done) next_state = GAP;
      GAP:   if (gap_last) next_state = last_byte ? IDLE : SHIFT;
      default: next_state = IDLE;
    endcase
  end

  // Every byte, including the last, is followed by a gap; tx_done marks the final gap cycle.
  always_comb begin
    start    = 1'b0;
    tx_done  = 1'b0;
    busy     = (state != IDLE);
    next_idx = (state == LOAD) ? 2'd0 : byte_idx + 2'd1;
    case (state)
      LOAD: start = 1'b1;
      GAP: begin
        if (gap_last) begin
          if (last_byte) tx_done = 1'b1;
          else           start   = 1'b1;
        end
      end
      default: ;
    endcase
    tx_byte = code;
    if (next_idx == 2'd0) tx_byte = CODE_EXT;
`ifdef ARROW_TX_BREAK_EN
    else if (is_break && next_idx == 2'd1) tx_byte = CODE_BREAK;
`endif
  end

  ps2_byte_tx #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_byte_tx (
    .clk      (clk),
    .areset_n (areset_n),
    .start    (start),
    .data     (tx_byte),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .done     (byte_done)
  );

endmodule
